// File: rtl/sev_seg_capture.sv
`default_nettype none
// =============================================================================
// Module      : sev_seg_capture
// Description : Decodes a scanned 4-digit seven-segment bus back into nibbles,
//               with per-digit valid, frame-complete, glyph-error and stall flags.
// Revision    : 1.0 - initial release
// =============================================================================
module sev_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] segEn,
    input  logic [6:0] seg,
    output logic [3:0] disp0,
    output logic [3:0] disp1,
    output logic [3:0] disp2,
    output logic [3:0] disp3,
    output logic [3:0] digitValid,
    output logic       frameDone,
    output logic       decodeErr,
    output logic       stalled
);
    localparam int            SW         = $clog2(STABLE_CYCLES + 1);
    localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] C_CNT_ONE  = SW'(1);
    localparam logic [SW-1:0] C_CNT_MAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] C_TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] C_TMO_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    logic [3:0]      samp_en_q;
    logic [6:0]      samp_seg_q;
    state_t          state_q, state_d;
    logic [3:0]      cur_en_q, cur_en_d;
    logic [6:0]      cur_seg_q, cur_seg_d;
    logic [SW-1:0]   stab_cnt_q, stab_cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0][3:0] disp_q, disp_d;
    logic [3:0]      valid_q, valid_d;
    logic [3:0]      seen_q, seen_d;
    logic            frame_q, frame_d;
    logic            err_q, err_d;
    logic            stalled_q, stalled_d;

    logic            w_single;
    logic            w_same;
    logic            w_capture;
    logic            w_legal;
    logic [3:0]      w_val;
    logic [3:0]      w_sel;
    logic [1:0]      w_idx;
    logic [3:0]      w_seen_new;
    logic [SW-1:0]   w_cnt_inc;

    // Returns {legal, value}; input is the active-high gfedcba pattern.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'h3F:   decode = {1'b1, 4'h0};
            7'h06:   decode = {1'b1, 4'h1};
            7'h5B:   decode = {1'b1, 4'h2};
            7'h4F:   decode = {1'b1, 4'h3};
            7'h66:   decode = {1'b1, 4'h4};
            7'h6D:   decode = {1'b1, 4'h5};
            7'h7D:   decode = {1'b1, 4'h6};
            7'h07:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h6F:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h7C:   decode = {1'b1, 4'hB};
            7'h39:   decode = {1'b1, 4'hC};
            7'h5E:   decode = {1'b1, 4'hD};
            7'h79:   decode = {1'b1, 4'hE};
            7'h71:   decode = {1'b1, 4'hF};
            default: decode = 5'b0_0000;
        endcase
    endfunction

    assign w_sel              = ~samp_en_q;
    assign w_single           = $onehot(w_sel);
    assign w_same             = (samp_en_q == cur_en_q) && (samp_seg_q == cur_seg_q);
    assign w_cnt_inc          = stab_cnt_q + C_CNT_ONE;
    assign {w_legal, w_val}   = decode(~samp_seg_q);
    assign w_seen_new         = seen_q | w_sel;

    always_comb begin
        w_idx = 2'd0;
        case (w_sel)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // Dwell tracker: capture fires on the STABLE_CYCLES-th identical sample.
    always_comb begin
        state_d    = state_q;
        cur_en_d   = cur_en_q;
        cur_seg_d  = cur_seg_q;
        stab_cnt_d = stab_cnt_q;
        w_capture  = 1'b0;
        if (!w_single) begin
            state_d = ST_IDLE;
        end else if (state_q != ST_IDLE && w_same) begin
            if (state_q == ST_DWELL) begin
                stab_cnt_d = w_cnt_inc;
                if (w_cnt_inc == C_CNT_MAX) begin
                    w_capture = 1'b1;
                    state_d   = ST_HELD;
                end
            end
        end else begin
            cur_en_d   = samp_en_q;
            cur_seg_d  = samp_seg_q;
            stab_cnt_d = C_CNT_ONE;
            if (C_CNT_MAX == C_CNT_ONE) begin
                w_capture = 1'b1;
                state_d   = ST_HELD;
            end else begin
                state_d = ST_DWELL;
            end
        end
    end

    always_comb begin
        disp_d    = disp_q;
        valid_d   = valid_q;
        seen_d    = seen_q;
        frame_d   = 1'b0;
        err_d     = 1'b0;
        stalled_d = stalled_q;
        tmo_d     = tmo_q;
        if (w_capture) begin
            tmo_d     = '0;
            stalled_d = 1'b0;
            if (w_legal) begin
                disp_d[w_idx]  = w_val;
                valid_d[w_idx] = 1'b1;
            end else begin
                valid_d[w_idx] = 1'b0;
                err_d          = 1'b1;
            end
            if (&w_seen_new) begin
                seen_d  = 4'b0000;
                frame_d = 1'b1;
            end else begin
                seen_d  = w_seen_new;
            end
        end else begin
            if (tmo_q != C_TMO_MAX) begin
                tmo_d = tmo_q + C_TMO_ONE;
            end
            if (tmo_q >= C_TMO_MAX - C_TMO_ONE) begin
                stalled_d = 1'b1;
                valid_d   = 4'b0000;
                seen_d    = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_en_q  <= 4'hF;
            samp_seg_q <= 7'h7F;
            state_q    <= ST_IDLE;
            cur_en_q   <= 4'hF;
            cur_seg_q  <= 7'h7F;
            stab_cnt_q <= '0;
            tmo_q      <= '0;
            disp_q     <= '0;
            valid_q    <= 4'b0000;
            seen_q     <= 4'b0000;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
            stalled_q  <= 1'b0;
        end else begin
            samp_en_q  <= segEn;
            samp_seg_q <= seg;
            state_q    <= state_d;
            cur_en_q   <= cur_en_d;
            cur_seg_q  <= cur_seg_d;
            stab_cnt_q <= stab_cnt_d;
            tmo_q      <= tmo_d;
            disp_q     <= disp_d;
            valid_q    <= valid_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            stalled_q  <= stalled_d;
        end
    end

    assign disp0      = disp_q[0];
    assign disp1      = disp_q[1];
    assign disp2      = disp_q[2];
    assign disp3      = disp_q[3];
    assign digitValid = valid_q;
    assign frameDone  = frame_q;
    assign decodeErr  = err_q;
    assign stalled    = stalled_q;

endmodule
`default_nettype wire

// File: tb/tb_sev_seg_capture.sv
`default_nettype none
// =============================================================================
// Module      : tb_sev_seg_capture
// Description : Directed vector table plus randomized scans against a
//               run-length reference model of the seven-segment capture.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_sev_seg_capture;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 16;
    localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] segEn = 4'hF;
    logic [6:0] seg = 7'h7F;
    logic [3:0] disp0, disp1, disp2, disp3, digitValid;
    logic       frameDone, decodeErr, stalled;

    sev_seg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .segEn(segEn), .seg(seg),
        .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
        .digitValid(digitValid), .frameDone(frameDone), .decodeErr(decodeErr),
        .stalled(stalled)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int fd_seen = 0;
    int err_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a digit is captured when the registered sample has been
    // the same single-active pattern for exactly STABLE consecutive cycles.
    logic [3:0] m_en = 4'hF, p_en = 4'hF;
    logic [6:0] m_seg = 7'h7F, p_seg = 7'h7F;
    int         run = 0, tmo = 0, m_d = 0, m_v = 0;
    bit         m_legal = 0;
    logic [3:0] e_disp [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_valid = 4'h0, e_seen = 4'h0;
    logic       e_fd = 1'b0, e_err = 1'b0, e_stall = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_en = 4'hF; m_seg = 7'h7F; run = 0; tmo = 0;
            for (int k = 0; k < 4; k++) e_disp[k] = 4'h0;
            e_valid = 4'h0; e_seen = 4'h0; e_fd = 1'b0; e_err = 1'b0; e_stall = 1'b0;
        end else begin
            e_fd = 1'b0; e_err = 1'b0;
            if ($countones(~m_en) == 1) begin
                if (run > 0 && m_en == p_en && m_seg == p_seg) run++;
                else run = 1;
            end else begin
                run = 0;
            end
            p_en = m_en; p_seg = m_seg;
            if (run == STABLE) begin
                for (int k = 0; k < 4; k++) if (!m_en[k]) m_d = k;
                m_legal = 0;
                for (int v = 0; v < 16; v++) if (GLY[v] == ~m_seg) begin m_legal = 1; m_v = v; end
                if (m_legal) begin e_disp[m_d] = 4'(m_v); e_valid[m_d] = 1'b1; end
                else begin e_valid[m_d] = 1'b0; e_err = 1'b1; end
                e_seen[m_d] = 1'b1;
                if (e_seen == 4'hF) begin e_fd = 1'b1; e_seen = 4'h0; end
                tmo = 0; e_stall = 1'b0;
            end else begin
                if (tmo < TIMEOUT) tmo++;
                if (tmo == TIMEOUT) begin e_stall = 1'b1; e_valid = 4'h0; e_seen = 4'h0; end
            end
            m_en = segEn; m_seg = seg;
        end
    end

    always @(negedge clk) begin
        chk("model", {9'h0, disp3, disp2, disp1, disp0, digitValid, frameDone, decodeErr, stalled},
            {9'h0, e_disp[3], e_disp[2], e_disp[1], e_disp[0], e_valid, e_fd, e_err, e_stall});
    end

    // Holds inputs for n rising edges; leaves time at 1 unit after the last edge.
    task automatic hold(input logic [3:0] en, input logic [6:0] pat, input int n);
        segEn = en; seg = ~pat;
        repeat (n) begin
            @(posedge clk); #1;
            fd_seen  += int'(frameDone);
            err_seen += int'(decodeErr);
        end
    endtask

    function automatic logic [31:0] dword();
        return {16'h0, disp3, disp2, disp1, disp0};
    endfunction

    typedef struct {
        logic [3:0]  en;
        logic [6:0]  pat;
        int          cycles;
        logic [15:0] exp_disp;
        logic [3:0]  exp_valid;
        int          exp_fd;
        int          exp_err;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{4'b1110, 7'h71, 8, 16'h000F, 4'b0001, 0, 0};
        tbl[1] = '{4'b1101, 7'h5B, 8, 16'h002F, 4'b0011, 0, 0};
        tbl[2] = '{4'b1011, 7'h06, 8, 16'h012F, 4'b0111, 0, 0};
        tbl[3] = '{4'b0111, 7'h3F, 8, 16'h012F, 4'b1111, 1, 0};
        tbl[4] = '{4'b1011, 7'h6D, 8, 16'h052F, 4'b1111, 0, 0};
        tbl[5] = '{4'b1011, 7'h49, 8, 16'h052F, 4'b1011, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_disp", dword(), 32'h0);
        chk("rst_flags", {27'h0, digitValid, stalled}, 32'h0);
        rst = 1'b0;

        fd_seen = 0; err_seen = 0;
        hold(4'b1110, 7'h4F, 5);
        chk("first_disp", dword(), 32'h0003);
        chk("first_valid", 32'(digitValid), 32'h1);
        hold(4'b1110, 7'h4F, 19);
        chk("hold_nofd", 32'(fd_seen), 32'h0);
        chk("hold_disp", dword(), 32'h0003);

        for (int i = 0; i < 6; i++) begin
            fd_seen = 0; err_seen = 0;
            hold(tbl[i].en, tbl[i].pat, tbl[i].cycles);
            chk($sformatf("vec%0d_disp", i), dword(), 32'(tbl[i].exp_disp));
            chk($sformatf("vec%0d_valid", i), 32'(digitValid), 32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_fd", i), 32'(fd_seen), 32'(tbl[i].exp_fd));
            chk($sformatf("vec%0d_err", i), 32'(err_seen), 32'(tbl[i].exp_err));
        end

        // Glitch inside a dwell restarts the stability count.
        fd_seen = 0; err_seen = 0;
        hold(4'b1101, 7'h66, 3);
        hold(4'b1101, 7'h67, 1);
        hold(4'b1101, 7'h66, 4);
        chk("glitch_early", 32'(disp1), 32'h2);
        hold(4'b1101, 7'h66, 1);
        chk("glitch_cap", 32'(disp1), 32'h4);
        chk("glitch_err", 32'(err_seen), 32'h0);
        hold(4'b1100, 7'h06, 10);
        chk("multi_disp", dword(), 32'h054F);
        chk("multi_valid", 32'(digitValid), 32'hB);

        fd_seen = 0;
        hold(4'b1110, 7'h7F, 8);
        hold(4'b1101, 7'h6F, 8);
        hold(4'b1011, 7'h77, 8);
        hold(4'b0111, 7'h7C, 8);
        chk("frame_disp", dword(), 32'hBA98);
        chk("frame_valid", 32'(digitValid), 32'hF);
        chk("frame_fd", 32'(fd_seen), 32'h1);

        hold(4'b1111, 7'h00, TIMEOUT);
        chk("tmo_stall", 32'(stalled), 32'h1);
        chk("tmo_valid", 32'(digitValid), 32'h0);
        chk("tmo_disp", dword(), 32'hBA98);
        hold(4'b1110, 7'h3F, 5);
        chk("unstall", 32'(stalled), 32'h0);
        chk("unstall_disp", dword(), 32'hBA90);
        chk("unstall_valid", 32'(digitValid), 32'h1);

        // Reset lands on the would-be capture edge.
        hold(4'b1011, 7'h7D, 4);
        rst = 1'b1;
        fd_seen = 0; err_seen = 0;
        hold(4'b1011, 7'h7D, 1);
        chk("rstcap_disp", dword(), 32'h0);
        chk("rstcap_flags", {27'h0, digitValid, stalled}, 32'h0);
        rst = 1'b0;
        hold(4'b1011, 7'h7D, 4);
        chk("rel_nocap", 32'(digitValid), 32'h0);
        hold(4'b1011, 7'h7D, 1);
        chk("rel_cap_disp", dword(), 32'h0600);
        chk("rel_cap_valid", 32'(digitValid), 32'h4);

        for (int i = 0; i < 250; i++) begin
            logic [3:0] en;
            logic [6:0] pat;
            int         r;
            r = int'($urandom_range(0, 99));
            if (r < 85) begin
                en = 4'hF;
                en[$urandom_range(0, 3)] = 1'b0;
            end else begin
                en = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 9) < 7) pat = GLY[$urandom_range(0, 15)];
            else pat = 7'($urandom_range(0, 127));
            if (r < 4) hold(4'hF, 7'h00, 20);
            else hold(en, pat, int'($urandom_range(1, 9)));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sev_seg_capture.md
Name: sev_seg_capture

Overview:
- Receive-side decoder for the 4-digit multiplexed seven-segment bus (segEn/sevSeg) that the display driver produces.
- Watches the scanned enable/segment lines, waits for each digit dwell to settle, and decodes the segment glyph back to its 4-bit hex value.
- Rebuilds the four displayed nibbles with per-digit valid flags, frame-complete pulses and error/stall reporting.
- Used for on-board readback/self-check and as the display monitor in system benches.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples of segEn and seg required before a digit is captured; legal range 1 to 255.
- TIMEOUT_CYCLES, 65536: cycles with no capture after which all digits are declared stale; legal range 16 to 2^24.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- segEn  input  4  digit enables, active-low; bit i low selects digit i (digit 0 is rightmost)
- seg  input  7  segments, active-low; seg[0]=a, seg[1]=b, … seg[6]=g
- disp0, disp1, disp2, disp3  output  4 each  last decoded value of digit 0/1/2/3
- digitValid  output  4  bit i set when dispi holds a good decode not yet invalidated
- frameDone  output  1  one-cycle pulse when all four digits have been captured since the last pulse
- decodeErr  output  1  one-cycle pulse when a settled pattern is not a legal hex glyph
- stalled  output  1  level; set on timeout, cleared by the next capture

Behaviour:
- Reset: disp0–disp3=0, digitValid=0, frameDone=0, decodeErr=0, stalled=0, seen-mask=0, timeout counter=0, FSM=IDLE. Reset has priority over all other events.
- Inputs are sampled each rising edge into registers; all decisions use the registered sample.
- "Single-active": exactly one segEn bit is low. Zero or more than one low counts as blanking.

FSM states and transitions:
- IDLE: no single-active sample.
  - A single-active sample loads cur_en and cur_seg, sets stab_cnt=1 and goes to DWELL.
  - If STABLE_CYCLES==1, capture occurs on that same sample and the FSM goes to HELD.
- DWELL: counting stability.
  - A sample equal to cur_en and cur_seg increments stab_cnt. When stab_cnt reaches STABLE_CYCLES, capture and go to HELD.
  - A different single-active sample reloads cur_en/cur_seg and restarts stab_cnt=1.
  - A blanking sample goes to IDLE.
- HELD: the digit is already captured for this dwell; no re-capture while the sample is unchanged.
  - Any change goes to IDLE or DWELL under the same rules as above.

Capture of digit i (takes effect the cycle after the STABLE_CYCLES-th matching sample):
- Decode ~cur_seg, ordered gfedcba. Legal glyphs:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Legal glyph: dispi=value, digitValid[i]=1.
- Illegal glyph (including all-off): dispi unchanged, digitValid[i]=0, decodeErr pulses.
- Either outcome: seen-mask[i]=1, timeout counter cleared, stalled=0.

Frame completion:
- When the seen-mask becomes 1111, frameDone pulses in the same cycle the capture results appear, and the seen-mask clears to 0000.
- The capture that completed the frame is not counted toward the next frame.
- Re-capturing an already-seen digit before the frame completes overwrites dispi and leaves the mask unchanged.

Timeout:
- The counter increments every cycle without a capture, saturating.
- On reaching TIMEOUT_CYCLES: stalled=1, digitValid=0000, seen-mask=0000. disp values are retained.

Simultaneous events:
- Capture and timeout in the same cycle: capture wins and the counter clears.
- A changed sample arriving on the would-be capture cycle means no capture; the dwell restarts.

Test Plan:
- Drive segEn=1110, seg=~7'h4F for 4 cycles → one cycle later disp0=3, digitValid=0001; holding 20 more cycles gives no further capture and no frameDone.
- Scan digits 0..3 with glyphs 0x71,0x5B,0x06,0x3F (F,2,1,0) at 8 cycles each → disp0=F, disp1=2, disp2=1, disp3=0; digitValid=1111; exactly one frameDone pulse after the digit-3 capture.
- Digit 2 with seg=~7'h49 for 4 cycles after a good decode of 5 → decodeErr one pulse, digitValid[2]=0, disp2 stays 5.
- Digit 1 glyph 0x66 held 3 cycles, then seg glitches to 0x67, then 0x66 for 4 cycles → exactly one capture with disp1=4, timed 4 cycles after the last change; segEn=1100 for 10 cycles → no capture.
- Valid frame, then segEn=1111 for TIMEOUT_CYCLES (bench override 16) → stalled=1, digitValid=0000, disp unchanged; next valid capture clears stalled.
- Assert rst on the would-be capture cycle → all outputs at reset values and no capture; after release, 4 stable cycles are needed for a capture.
